mem_access_unit: RTL

- MEM-stage consumer of the EX/MEM pipeline register: takes the registered ALU result, writeback info and load/store flags, and performs the data-memory access.
- Drives a request/grant/response data-memory bus and generates byte enables and store lane replication.
- Sign/zero-extends load data; holds the upstream pipeline (stall_out) while an access is outstanding.
- Feeds registered writeback data to the MEM/WB path.

---
 rtl/mem_access_unit_pkg.sv | 56 +++++
 rtl/mem_access_unit_align.sv | 73 +++++++
 rtl/mem_access_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared encodings for the MEM stage: one-hot load/store flag encodings,
// FSM state constants, reset/boolean helpers and the access-size decode
// shared by the top and the alignment sub-module.
// ---------------------------------------------------------------------------
package mem_access_unit_pkg;

   // Load flags, one-hot {LBU,LHU,LW,LH,LB}
   localparam logic [4:0] NO_LOAD  = 5'b00000;
   localparam logic [4:0] LB       = 5'b00001;
   localparam logic [4:0] LH       = 5'b00010;
   localparam logic [4:0] LW       = 5'b00100;
   localparam logic [4:0] LHU      = 5'b01000;
   localparam logic [4:0] LBU      = 5'b10000;

   // Store flags, one-hot {SW,SH,SB}
   localparam logic [2:0] NO_STORE = 3'b000;
   localparam logic [2:0] SB       = 3'b001;
   localparam logic [2:0] SH       = 3'b010;
   localparam logic [2:0] SW       = 3'b100;

   // FSM states
   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] REQ      = 2'd1;
   localparam logic [1:0] WAIT     = 2'd2;

   localparam logic [31:0] ZERO_32BIT = 32'h0000_0000;
   localparam logic        RST_ENABLE = 1'b1;
   localparam logic        TRUE       = 1'b1;
   localparam logic        FALSE      = 1'b0;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } acc_size_e;

   // A nonzero load flag wins over any store flag.
   function automatic acc_size_e access_size(input logic [4:0] load_flag,
                                             input logic [2:0] store_flag);
      acc_size_e sz;
      sz = SZ_WORD;
      if (load_flag != NO_LOAD) begin
         if (load_flag == LB || load_flag == LBU)      sz = SZ_BYTE;
         else if (load_flag == LH || load_flag == LHU) sz = SZ_HALF;
         else                                          sz = SZ_WORD;
      end else if (store_flag == SB) begin
         sz = SZ_BYTE;
      end else if (store_flag == SH) begin
         sz = SZ_HALF;
      end
      return sz;
   endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// ---------------------------------------------------------------------------
// mem_access_unit_align (mem_align)
// Purely combinational lane logic for the MEM stage.
// Request side (current EX/MEM inputs):
//   i_addr_lo, i_load_flag, i_store_flag, i_store_data
//   -> o_mem_op, o_is_load, o_misalign, o_be, o_wdata
// Response side (latched access info):
//   i_rsp_load_type, i_rsp_addr_lo, i_rdata -> o_load_data
// ---------------------------------------------------------------------------
module mem_access_unit_align
   import mem_access_unit_pkg::*;
(
   input  logic [1:0]  i_addr_lo,
   input  logic [4:0]  i_load_flag,
   input  logic [2:0]  i_store_flag,
   input  logic [31:0] i_store_data,
   output logic        o_mem_op,
   output logic        o_is_load,
   output logic        o_misalign,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   input  logic [4:0]  i_rsp_load_type,
   input  logic [1:0]  i_rsp_addr_lo,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_load_data
);

   acc_size_e   w_size;
   logic [31:0] w_lane;

   assign o_is_load = (i_load_flag != NO_LOAD);
   assign o_mem_op  = o_is_load || (i_store_flag != NO_STORE);
   assign w_size    = access_size(i_load_flag, i_store_flag);

   always_comb begin
      o_be       = 4'b0000;
      o_wdata    = ZERO_32BIT;
      o_misalign = FALSE;
      case (w_size)
         SZ_BYTE: begin
            o_be    = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_store_data[7:0]}};
         end
         SZ_HALF: begin
            o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_wdata    = {2{i_store_data[15:0]}};
            o_misalign = i_addr_lo[0];
         end
         default: begin
            o_be       = 4'b1111;
            o_wdata    = i_store_data;
            o_misalign = (i_addr_lo != 2'b00);
         end
      endcase
      // Loads never drive write data; non-memory ops are never misaligned.
      if (o_is_load) o_wdata = ZERO_32BIT;
      if (!o_mem_op) o_misalign = FALSE;
   end

   // Shift the addressed lane down to bit 0, then extend per load type.
   assign w_lane = i_rdata >> {i_rsp_addr_lo, 3'b000};

   always_comb begin
      case (i_rsp_load_type)
         LB:      o_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
         LBU:     o_load_data = {24'h000000, w_lane[7:0]};
         LH:      o_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
         LHU:     o_load_data = {16'h0000, w_lane[15:0]};
         default: o_load_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// MEM-stage consumer of the EX/MEM register. ALU results pass straight to
// writeback with one cycle of latency; aligned loads/stores go out on a
// request/grant/response data bus while stall_out holds upstream stages.
//
// Ports:
//   clk, rst (async, active-high)
//   rd_in, rd_en_in, rd_addr_in         ALU result / effective address, wb info
//   load_flag_in, store_flag_in         one-hot op flags (load wins)
//   store_data_in                       rs2 for stores
//   stall_out                           hold EX/MEM and earlier
//   dmem_req/we/addr/be/wdata           bus request (registered)
//   dmem_gnt, dmem_rvalid, dmem_rdata, dmem_err   bus grant/response
//   wb_data, wb_en, wb_addr             registered writeback
//   misalign, bus_err                   one-cycle event pulses
//   o_dbg_state                         current FSM state
//
// Bus handshake: dmem_req is held with addr/be/wdata/we stable until the
// cycle dmem_gnt is seen high; exactly one dmem_rvalid cycle (with
// dmem_err as qualifier) then completes the access. dmem_rvalid outside
// WAIT is ignored.
//
// Optional feature: define MEM_TIMEOUT_EN to abort an access that spends
// TIMEOUT_CYCLES cycles in REQ+WAIT (bus_err pulse, stall released).
// ---------------------------------------------------------------------------
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int XREG_ADDRWIDTH = 5,
   parameter int TIMEOUT_CYCLES = 255
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [XLEN-1:0]           rd_in,
   input  logic                      rd_en_in,
   input  logic [XREG_ADDRWIDTH-1:0] rd_addr_in,
   input  logic [4:0]                load_flag_in,
   input  logic [2:0]                store_flag_in,
   input  logic [XLEN-1:0]           store_data_in,
   output logic                      stall_out,
   output logic                      dmem_req,
   output logic                      dmem_we,
   output logic [XLEN-1:0]           dmem_addr,
   output logic [3:0]                dmem_be,
   output logic [XLEN-1:0]           dmem_wdata,
   input  logic                      dmem_gnt,
   input  logic                      dmem_rvalid,
   input  logic [XLEN-1:0]           dmem_rdata,
   input  logic                      dmem_err,
   output logic [XLEN-1:0]           wb_data,
   output logic                      wb_en,
   output logic [XREG_ADDRWIDTH-1:0] wb_addr,
   output logic                      misalign,
   output logic                      bus_err,
   output logic [1:0]                o_dbg_state
);

   logic [1:0]                r_state;
   logic                      r_req;
   logic                      r_we;
   logic [XLEN-1:0]           r_addr;
   logic [3:0]                r_be;
   logic [XLEN-1:0]           r_wdata;
   logic [XLEN-1:0]           r_wb_data;
   logic                      r_wb_en;
   logic [XREG_ADDRWIDTH-1:0] r_wb_addr;
   logic                      r_misalign;
   logic                      r_bus_err;
   logic [4:0]                r_load_type;
   logic [XREG_ADDRWIDTH-1:0] r_lat_rd_addr;
   logic                      r_lat_rd_en;

   logic                      w_mem_op;
   logic                      w_is_load;
   logic                      w_misalign;
   logic [3:0]                w_be;
   logic [XLEN-1:0]           w_wdata;
   logic [XLEN-1:0]           w_load_data;
   logic                      w_timeout;

   mem_access_unit_align u_align (
      .i_addr_lo       (rd_in[1:0]),
      .i_load_flag     (load_flag_in),
      .i_store_flag    (store_flag_in),
      .i_store_data    (store_data_in),
      .o_mem_op        (w_mem_op),
      .o_is_load       (w_is_load),
      .o_misalign      (w_misalign),
      .o_be            (w_be),
      .o_wdata         (w_wdata),
      .i_rsp_load_type (r_load_type),
      .i_rsp_addr_lo   (r_addr[1:0]),
      .i_rdata         (dmem_rdata),
      .o_load_data     (w_load_data)
   );

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_cnt;

   // Held at zero in IDLE so it starts from zero on entry to REQ.
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE)   r_cnt <= '0;
      else if (r_state == IDLE) r_cnt <= '0;
      else                      r_cnt <= r_cnt + 1'b1;
   end

   // True in the cycle whose closing edge makes the count reach the limit.
   assign w_timeout = (r_state == REQ || r_state == WAIT) &&
                      (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
   assign w_timeout        = FALSE;
`endif

   // A timing-out access releases the stall in its final cycle so the
   // upstream instruction advances rather than being reissued.
   always_comb begin
      case (r_state)
         IDLE:    stall_out = w_mem_op && !w_misalign;
         REQ:     stall_out = !w_timeout;
         WAIT:    stall_out = !dmem_rvalid && !w_timeout;
         default: stall_out = FALSE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         r_state       <= IDLE;
         r_req         <= FALSE;
         r_we          <= FALSE;
         r_addr        <= ZERO_32BIT;
         r_be          <= 4'b0000;
         r_wdata       <= ZERO_32BIT;
         r_wb_data     <= ZERO_32BIT;
         r_wb_en       <= FALSE;
         r_wb_addr     <= '0;
         r_misalign    <= FALSE;
         r_bus_err     <= FALSE;
         r_load_type   <= NO_LOAD;
         r_lat_rd_addr <= '0;
         r_lat_rd_en   <= FALSE;
      end else begin
         r_misalign <= FALSE;
         r_bus_err  <= FALSE;
         case (r_state)
            IDLE: begin
               if (!w_mem_op) begin
                  r_wb_data <= rd_in;
                  r_wb_en   <= rd_en_in;
                  r_wb_addr <= rd_addr_in;
               end else if (w_misalign) begin
                  r_misalign <= TRUE;
                  r_wb_en    <= FALSE;
               end else begin
                  r_addr        <= rd_in;
                  r_be          <= w_be;
                  r_wdata       <= w_wdata;
                  r_we          <= !w_is_load;
                  r_load_type   <= load_flag_in;
                  r_lat_rd_addr <= rd_addr_in;
                  r_lat_rd_en   <= rd_en_in;
                  r_wb_en       <= FALSE;
                  r_req         <= TRUE;
                  r_state       <= REQ;
               end
            end
            REQ: begin
               r_wb_en <= FALSE;
               if (w_timeout) begin
                  r_req     <= FALSE;
                  r_bus_err <= TRUE;
                  r_state   <= IDLE;
               end else if (dmem_gnt) begin
                  r_req   <= FALSE;
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               r_wb_en <= FALSE;
               if (dmem_rvalid) begin
                  r_state <= IDLE;
                  if (dmem_err) begin
                     r_bus_err <= TRUE;
                  end else if (!r_we) begin
                     r_wb_data <= w_load_data;
                     r_wb_en   <= r_lat_rd_en;
                     r_wb_addr <= r_lat_rd_addr;
                  end
               end else if (w_timeout) begin
                  r_bus_err <= TRUE;
                  r_state   <= IDLE;
               end
            end
            default: begin
               r_req   <= FALSE;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign dmem_req    = r_req;
   assign dmem_we     = r_we;
   assign dmem_addr   = r_addr;
   assign dmem_be     = r_be;
   assign dmem_wdata  = r_wdata;
   assign wb_data     = r_wb_data;
   assign wb_en       = r_wb_en;
   assign wb_addr     = r_wb_addr;
   assign misalign    = r_misalign;
   assign bus_err     = r_bus_err;
   assign o_dbg_state = r_state;

endmodule
